// File: rtl/des_key_sched.sv
// DES round-key generator: PC-1 load, per-round C/D rotation, PC-2 output with valid/ready.
// Optional DES_KEY_PARITY_CHECK_EN adds a registered odd-parity check on key_in bytes.
module des_key_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    input  logic        start,
    output logic        busy,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [47:0] subkey,
    output logic [3:0]  round_idx,
    output logic        last_key
`ifdef DES_KEY_PARITY_CHECK_EN
    ,
    output logic        parity_err
`endif
);

    // Tables use FIPS numbering: bit 1 is the MSB.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic [27:0] c_reg, d_reg;
    logic        dec_q;
    logic        load, fire, advance;
    logic [55:0] pc1_key;

    function automatic logic [55:0] pc1_perm(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
        return r;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
        return r;
    endfunction

    // Rounds 1, 2, 9 and 16 (0-based 0, 1, 8, 15) shift by one, all others by two.
    function automatic logic one_shift(input logic [3:0] idx);
        return (idx == 4'd0) || (idx == 4'd1) || (idx == 4'd8) || (idx == 4'd15);
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic one);
        return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic one);
        return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    assign pc1_key      = pc1_perm(key_in);
    assign busy         = (state == RUN);
    assign subkey_valid = (state == RUN);
    assign subkey       = pc2_perm({c_reg, d_reg});
    assign last_key     = (state == RUN) && (dec_q ? (round_idx == 4'd0) : (round_idx == 4'd15));

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        fire      = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                load = start;
                if (start) state_nxt = RUN;
            end
            RUN: begin
                fire    = subkey_ready;
                advance = subkey_ready && !last_key;
                if (subkey_ready && last_key) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Decrypt loads the unrotated PC-1 value, which equals C16/D16 after a full 28-bit rotation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_reg     <= '0;
            d_reg     <= '0;
            round_idx <= '0;
            dec_q     <= 1'b0;
        end else if (load) begin
            dec_q <= decrypt;
            if (decrypt) begin
                c_reg     <= pc1_key[55:28];
                d_reg     <= pc1_key[27:0];
                round_idx <= 4'd15;
            end else begin
                c_reg     <= rotl(pc1_key[55:28], 1'b1);
                d_reg     <= rotl(pc1_key[27:0], 1'b1);
                round_idx <= 4'd0;
            end
        end else if (advance) begin
            if (dec_q) begin
                c_reg     <= rotr(c_reg, one_shift(round_idx));
                d_reg     <= rotr(d_reg, one_shift(round_idx));
                round_idx <= round_idx - 4'd1;
            end else begin
                c_reg     <= rotl(c_reg, one_shift(round_idx + 4'd1));
                d_reg     <= rotl(d_reg, one_shift(round_idx + 4'd1));
                round_idx <= round_idx + 4'd1;
            end
        end
    end

`ifdef DES_KEY_PARITY_CHECK_EN
    // Every key byte must have odd parity; an even byte flags an error.
    logic parity_bad;
    always_comb begin
        parity_bad = 1'b0;
        for (int b = 0; b < 8; b++) parity_bad = parity_bad | ~(^key_in[b*8 +: 8]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       parity_err <= 1'b0;
        else if (load) parity_err <= parity_bad;
    end
`endif

endmodule
